i2s_rx: RTL and testbench

Receive-side I2S deserializer: the capture path for an I2S ADC or codec. It samples serial data on the rising edges of the bit clock and word-select signals produced by i2s_clk. It assembles left/right words of DW bits and presents each complete stereo frame on a valid/ready output. It pairs with i2s_tx, which drives the DAC, so audio can be looped back and processed in the clk domain.

---
 rtl/i2s_rx.sv | 170 +++++++++++++++++
 tb/tb_i2s_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// I2S receive deserializer. Captures left/right words of DW bits and
// presents each complete stereo frame on a valid/ready output register.
module i2s_rx #(
    parameter int DW = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 lrclk,
    input  logic                 sdi,
    output logic signed [DW-1:0] l_sample,
    output logic signed [DW-1:0] r_sample,
    output logic                 valid,
    input  logic                 ready,
    output logic                 overrun,
    output logic                 frame_err
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        ARM   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            sclk_q, sclk_d;
    logic            lr_q, lr_d;
    logic            chan_q, chan_d;          // 0 = left slot, 1 = right slot
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic [DW-1:0]   left_hold_q, left_hold_d;
    logic            have_left_q, have_left_d;
    logic [DW-1:0]   l_sample_q, l_sample_d;
    logic [DW-1:0]   r_sample_q, r_sample_d;
    logic            valid_q, valid_d;
    logic            overrun_q, overrun_d;
    logic            frame_err_q, frame_err_d;

    logic            rise;
    logic            boundary;
    logic            publish;
    logic [DW-1:0]   word;
    logic [CW-1:0]   cnt_inc;

    // Edge detection, capture FSM, word assembly and output register update
    always_comb begin
        state_d     = state_q;
        sclk_d      = sclk;
        lr_d        = lr_q;
        chan_d      = chan_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        left_hold_d = left_hold_q;
        have_left_d = have_left_q;
        l_sample_d  = l_sample_q;
        r_sample_d  = r_sample_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
        publish     = 1'b0;

        rise     = sclk && !sclk_q;
        boundary = rise && (lrclk != lr_q);
        word     = {shift_q[DW-2:0], sdi};
        cnt_inc  = cnt_q + CW'(1);

        if (rise) begin
            lr_d = lrclk;
            case (state_q)
                SYNC: begin
                    // Only a left-slot boundary can start a frame
                    if (boundary && !lrclk) begin
                        state_d = ARM;
                        chan_d  = 1'b0;
                    end
                end
                ARM, SHIFT: begin
                    if (boundary) begin
                        // Slot ended early: drop the partial word and frame
                        have_left_d = 1'b0;
                        frame_err_d = 1'b1;
                        chan_d      = 1'b0;
                        state_d     = lrclk ? SYNC : ARM;
                    end else if (state_q == ARM) begin
                        shift_d = {{(DW-1){1'b0}}, sdi};
                        cnt_d   = CW'(1);
                        state_d = SHIFT;
                    end else begin
                        shift_d = word;
                        cnt_d   = cnt_inc;
                        if (cnt_inc == CW'(DW)) begin
                            state_d = DONE;
                            if (!chan_q) begin
                                left_hold_d = word;
                                have_left_d = 1'b1;
                            end else if (have_left_q) begin
                                publish     = 1'b1;
                                have_left_d = 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    // Trailing slot bits are ignored until the next boundary
                    if (boundary) begin
                        if (!lrclk && have_left_q) begin
                            have_left_d = 1'b0;
                        end
                        chan_d  = lrclk;
                        state_d = ARM;
                    end
                end
                default: state_d = SYNC;
            endcase
        end

        if (publish) begin
            // A frame still pending with ready low is lost here
            l_sample_d = left_hold_q;
            r_sample_d = word;
            valid_d    = 1'b1;
            overrun_d  = valid_q && !ready;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SYNC;
            sclk_q      <= 1'b0;
            lr_q        <= 1'b0;
            chan_q      <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            have_left_q <= 1'b0;
            l_sample_q  <= '0;
            r_sample_q  <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_q      <= sclk_d;
            lr_q        <= lr_d;
            chan_q      <= chan_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            have_left_q <= have_left_d;
            l_sample_q  <= l_sample_d;
            r_sample_q  <= r_sample_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign l_sample  = l_sample_q;
    assign r_sample  = r_sample_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: table of full frames plus hand-written
// sequences for alignment, backpressure, truncation and async reset.
module tb_i2s_rx;

    localparam int DW = 24;

    logic                 clk;
    logic                 rst;
    logic                 sclk;
    logic                 lrclk;
    logic                 sdi;
    logic signed [DW-1:0] l_sample;
    logic signed [DW-1:0] r_sample;
    logic                 valid;
    logic                 ready;
    logic                 overrun;
    logic                 frame_err;

    i2s_rx #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .lrclk     (lrclk),
        .sdi       (sdi),
        .l_sample  (l_sample),
        .r_sample  (r_sample),
        .valid     (valid),
        .ready     (ready),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Observation state written by the monitor
    int          cyc       = 0;
    int          acc_n     = 0;
    int          vcyc_n    = 0;
    int          ovr_n     = 0;
    int          ferr_n    = 0;
    int          rise_cyc  = -1;
    int          lsb_cyc   = -1;
    logic        valid_prev = 1'b0;
    logic [DW-1:0] last_l  = '0;
    logic [DW-1:0] last_r  = '0;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (valid) vcyc_n = vcyc_n + 1;
            if (valid && !valid_prev) rise_cyc = cyc;
            valid_prev = valid;
            if (overrun) ovr_n = ovr_n + 1;
            if (frame_err) ferr_n = ferr_n + 1;
            if (valid && ready) begin
                acc_n  = acc_n + 1;
                last_l = l_sample;
                last_r = r_sample;
                $display("frame accepted l=%06h r=%06h cyc=%0d", l_sample, r_sample, cyc);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One slot: delay bit, DW data bits MSB first, then fill bits; cut at width
    task automatic send_slot(input logic lr, input logic [DW-1:0] w,
                             input int width, input logic fill);
        for (int k = 0; k < width; k++) begin
            sclk  = 1'b0;
            lrclk = lr;
            if (k >= 1 && k <= DW) sdi = w[DW-k];
            else                   sdi = fill;
            repeat (4) tick();
            sclk = 1'b1;
            if (lr && k == DW) lsb_cyc = cyc;
            repeat (4) tick();
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                              input int width, input logic fill);
        send_slot(1'b0, l, width, fill);
        send_slot(1'b1, r, width, fill);
    endtask

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        int            width;
        logic          fill;
        logic [DW-1:0] exp_l;
        logic [DW-1:0] exp_r;
    } vec_t;

    vec_t vecs[4];

    int a0, f0, o0, v0;

    initial begin
        vecs[0] = '{l: 24'h800000, r: 24'h7FFFFF, width: 32, fill: 1'b1,
                    exp_l: 24'h800000, exp_r: 24'h7FFFFF};
        vecs[1] = '{l: 24'h000001, r: 24'hFFFFFF, width: 25, fill: 1'b0,
                    exp_l: 24'h000001, exp_r: 24'hFFFFFF};
        vecs[2] = '{l: 24'hA5A5A5, r: 24'h5A5A5A, width: 28, fill: 1'b1,
                    exp_l: 24'hA5A5A5, exp_r: 24'h5A5A5A};
        vecs[3] = '{l: 24'hFFFFFF, r: 24'h000000, width: 32, fill: 1'b0,
                    exp_l: 24'hFFFFFF, exp_r: 24'h000000};

        rst   = 1'b1;
        sclk  = 1'b0;
        lrclk = 1'b1;
        sdi   = 1'b0;
        ready = 1'b1;
        repeat (3) tick();
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_l", 32'(l_sample), 32'h0);
        chk("reset_r", 32'(r_sample), 32'h0);
        chk("reset_overrun", 32'(overrun), 32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;

        // Released in the middle of a right slot
        send_slot(1'b1, 24'h5A5A5A, 12, 1'b0);
        chk("align_tail_no_frame", 32'(acc_n), 32'h0);
        send_slot(1'b0, 24'h123456, 25, 1'b0);
        chk("align_left_no_frame", 32'(acc_n), 32'h0);
        v0 = vcyc_n;
        send_slot(1'b1, 24'hABCDEF, 25, 1'b0);
        chk("basic_accepts", 32'(acc_n), 32'h1);
        chk("basic_valid_cycles", 32'(vcyc_n - v0), 32'h1);
        chk("basic_l", 32'(last_l), 32'h123456);
        chk("basic_r", 32'(last_r), 32'hABCDEF);
        chk("basic_latency", 32'(rise_cyc), 32'(lsb_cyc + 1));
        chk("basic_no_err", 32'(ferr_n), 32'h0);
        chk("basic_no_overrun", 32'(ovr_n), 32'h0);

        // Table of full frames with ready held high
        for (int i = 0; i < 4; i++) begin
            a0 = acc_n;
            f0 = ferr_n;
            send_frame(vecs[i].l, vecs[i].r, vecs[i].width, vecs[i].fill);
            chk($sformatf("vec%0d_accepts", i), 32'(acc_n - a0), 32'h1);
            chk($sformatf("vec%0d_l", i), 32'(last_l), 32'(vecs[i].exp_l));
            chk($sformatf("vec%0d_r", i), 32'(last_r), 32'(vecs[i].exp_r));
            chk($sformatf("vec%0d_no_err", i), 32'(ferr_n - f0), 32'h0);
        end

        // Backpressure across two frames
        ready = 1'b0;
        a0 = acc_n;
        o0 = ovr_n;
        send_frame(24'h111111, 24'h222222, 25, 1'b0);
        chk("bp_a_valid", 32'(valid), 32'h1);
        chk("bp_a_no_overrun", 32'(ovr_n - o0), 32'h0);
        send_frame(24'h333333, 24'h444444, 25, 1'b0);
        chk("bp_overrun_once", 32'(ovr_n - o0), 32'h1);
        chk("bp_l_is_b", 32'(l_sample), 32'h333333);
        chk("bp_r_is_b", 32'(r_sample), 32'h444444);
        chk("bp_b_valid", 32'(valid), 32'h1);
        ready = 1'b1;
        tick();
        chk("bp_valid_cleared", 32'(valid), 32'h0);
        chk("bp_accepts", 32'(acc_n - a0), 32'h1);
        chk("bp_l_held", 32'(l_sample), 32'h333333);

        // Truncated left slot
        a0 = acc_n;
        f0 = ferr_n;
        send_slot(1'b0, 24'hFEDCBA, 10, 1'b0);
        send_slot(1'b1, 24'h0F0F0F, 25, 1'b0);
        chk("trunc_err_once", 32'(ferr_n - f0), 32'h1);
        chk("trunc_no_frame", 32'(acc_n - a0), 32'h0);
        send_frame(24'h13579B, 24'h2468AC, 25, 1'b0);
        chk("trunc_next_accepts", 32'(acc_n - a0), 32'h1);
        chk("trunc_next_l", 32'(last_l), 32'h13579B);
        chk("trunc_next_r", 32'(last_r), 32'h2468AC);
        chk("trunc_next_no_err", 32'(ferr_n - f0), 32'h1);

        // Asynchronous reset in the middle of a left word
        send_slot(1'b0, 24'h765432, 12, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("areset_l", 32'(l_sample), 32'h0);
        chk("areset_r", 32'(r_sample), 32'h0);
        chk("areset_valid", 32'(valid), 32'h0);
        chk("areset_pulses", 32'({overrun, frame_err}), 32'h0);
        repeat (3) tick();
        rst = 1'b0;
        a0 = acc_n;
        f0 = ferr_n;
        send_slot(1'b0, 24'h765432, 5, 1'b0);
        send_slot(1'b1, 24'h999999, 25, 1'b0);
        chk("areset_no_early_frame", 32'(acc_n - a0), 32'h0);
        send_frame(24'h0A0B0C, 24'hF0E0D0, 32, 1'b1);
        chk("areset_accepts", 32'(acc_n - a0), 32'h1);
        chk("areset_next_l", 32'(last_l), 32'h0A0B0C);
        chk("areset_next_r", 32'(last_r), 32'hF0E0D0);
        chk("areset_no_err", 32'(ferr_n - f0), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
